cfg_chain_loader: RTL and testbench
===================================

CFG_CHAIN_LOADER -- requirements
Module: cfg_chain_loader

Interface
REQ-001 SHALL have parameter WORD_W, default 32, meaning the width of the configuration words accepted upstream.
REQ-002 SHALL have parameter CHAIN_LEN, default 100, meaning the total number of bits in the downstream PE configuration chain (CHAIN_LEN >= 1).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a chain load.
REQ-006 SHALL have port word_in, input, WORD_W bits: configuration word from the upstream source.
REQ-007 SHALL have port word_valid, input, 1 bit: word_in holds valid data.
REQ-008 SHALL have port word_ready, output, 1 bit: the loader accepts word_in this cycle.
REQ-009 SHALL have port cfg_data, output, 1 bit: serial bit driven into the chain head (config_in of the first PE).
REQ-010 SHALL have port cfg_shift, output, 1 bit: chain clock-enable; the chain advances one bit on each cycle in which it is high.
REQ-011 SHALL have port cfg_rst, output, 1 bit: chain clear pulse, driving config_reset.
REQ-012 SHALL have port busy, output, 1 bit: a load is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a load completes.
REQ-014 SHALL have port csum, output, 16 bits: configuration checksum (see Configuration).

Function
REQ-015 SHALL implement the FSM states IDLE, CLEAR, LOAD, SHIFT and FIN.
REQ-016 IDLE: start=1 -> CLEAR; otherwise stay in IDLE; start is ignored in all other states.
REQ-017 CLEAR: cfg_rst=1 for exactly one cycle, bit counter := 0 -> LOAD.
REQ-018 LOAD: word_ready=1; on word_valid&&word_ready, latch word_in into the shift register -> SHIFT; with word_valid=0, stay in LOAD indefinitely with no outputs other than busy changing.
REQ-019 SHIFT: each cycle cfg_shift=1 and cfg_data=shift_reg[0], shift the register right by 1, and increment the bit counter.
REQ-020 SHIFT: when the bit counter reaches CHAIN_LEN -> FIN; else, once WORD_W bits of the current word have been sent -> LOAD.
REQ-021 The final word SHALL send only CHAIN_LEN mod WORD_W bits (WORD_W if that is 0); its unused upper bits SHALL be discarded.
REQ-022 Bit order SHALL be word 0 bit 0 first, LSB-first within each word; the loader SHALL accept exactly ceil(CHAIN_LEN/WORD_W) words per load.
REQ-023 FIN: done=1 for one cycle -> IDLE.
REQ-024 busy SHALL be 1 in CLEAR, LOAD, SHIFT and FIN, and 0 in IDLE.
REQ-025 cfg_shift and word_ready SHALL never both be 1 in the same cycle.
REQ-026 cfg_data SHALL be 0 whenever cfg_shift=0.
REQ-027 The bit counter SHALL be ceil(log2(CHAIN_LEN+1)) bits wide and SHALL never wrap.

Reset
REQ-028 While reset=1, the loader SHALL force IDLE and set word_ready, cfg_data, cfg_shift, cfg_rst, busy, done, csum, the bit counter and the shift register to 0.
REQ-029 reset asserted mid-load SHALL abort the load on the next edge with no done pulse and no further cfg_shift; the chain is left partially loaded.
REQ-030 start asserted in the first cycle after reset deasserts SHALL be honoured.

Configuration
REQ-031 Macro CFG_LOADER_CSUM_EN defined: csum SHALL be cleared in CLEAR and, on each accepted word, add its low and high 16-bit halves modulo 2^16 (a zero-padded high half when WORD_W<=16, full words including discarded bits); csum holds its value until the next CLEAR.
REQ-032 Macro CFG_LOADER_CSUM_EN undefined: csum SHALL be constant 0 and no checksum logic SHALL be synthesised.

Verification
REQ-033 Defaults, start pulse, words 0x00000001, 0x80000000, 0xFFFFFFFF, 0x0000000F always valid -> cfg_rst 1 cycle; 100 cfg_shift cycles; cfg_data =1 at bit 0, 63, 64..95, 96..99, 0 elsewhere; done at cycle 1+4+100+1 after start.
REQ-034 word_valid withheld for 10 cycles before the second word -> busy stays 1, cfg_shift stays 0 during the gap, total serial stream unchanged.
REQ-035 start pulsed repeatedly during SHIFT -> no restart and no extra cfg_rst; exactly one done.
REQ-036 reset at bit 40 of 100 -> next cycle busy=0, cfg_shift=0, done never pulses; a new start gives a full, correct load.
REQ-037 CHAIN_LEN=32, WORD_W=32 -> exactly one word accepted, 32 shifts, done; CHAIN_LEN=1 -> one shift of word bit 0.
REQ-038 CFG_LOADER_CSUM_EN defined, words 0x00010002 and 0xFFFF0001 -> csum=0x0003 after load; macro undefined -> csum=0 throughout.

Source files
------------

// File: rtl/cfg_chain_loader.sv
// Serial configuration-chain loader: accepts WORD_W-bit words and shifts CHAIN_LEN bits
// LSB-first into a PE config chain. Optional checksum under CFG_LOADER_CSUM_EN.
module cfg_chain_loader #(
  parameter int WORD_W    = 32,
  parameter int CHAIN_LEN = 100
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_data,
  output logic              cfg_shift,
  output logic              cfg_rst,
  output logic              busy,
  output logic              done,
  output logic [15:0]       csum
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int WB_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [WB_W-1:0]  WB_LAST  = WB_W'(WORD_W - 1);
  localparam logic [WB_W-1:0]  WB_ONE   = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_SHIFT = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [WB_W-1:0]   wbit_q,  wbit_d;

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    wbit_d  = wbit_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        cnt_d   = '0;
        wbit_d  = '0;
        state_d = S_LOAD;
      end
      S_LOAD:  if (word_valid) begin
        shreg_d = word_in;
        wbit_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        shreg_d = shreg_q >> 1;
        cnt_d   = cnt_q + CNT_ONE;
        wbit_d  = wbit_q + WB_ONE;
        // chain end wins over word end, so the last word's upper bits are dropped
        if (cnt_q == LAST_BIT)     state_d = S_FIN;
        else if (wbit_q == WB_LAST) state_d = S_LOAD;
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      wbit_q  <= '0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      wbit_q  <= wbit_d;
    end
  end

  assign word_ready = (state_q == S_LOAD);
  assign cfg_shift  = (state_q == S_SHIFT);
  assign cfg_data   = cfg_shift & shreg_q[0];
  assign cfg_rst    = (state_q == S_CLEAR);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_FIN);

`ifdef CFG_LOADER_CSUM_EN
  logic [15:0] csum_q, csum_d;
  logic [31:0] wpad;

  // checksum covers the full accepted word, including bits later discarded
  if (WORD_W >= 32) begin : g_wide
    assign wpad = word_in[31:0];
  end else begin : g_narrow
    assign wpad = {{(32-WORD_W){1'b0}}, word_in};
  end

  always_comb begin
    csum_d = csum_q;
    if (state_q == S_CLEAR)                   csum_d = '0;
    else if (state_q == S_LOAD && word_valid) csum_d = csum_q + wpad[15:0] + wpad[31:16];
  end

  always_ff @(posedge clk) begin
    if (reset) csum_q <= '0;
    else       csum_q <= csum_d;
  end

  assign csum = csum_q;
`else
  assign csum = 16'd0;
`endif

endmodule

// File: tb/tb_cfg_chain_loader.sv
// Directed bench for cfg_chain_loader: table of full loads on the default build plus
// hand sequences for reset abort and the short-chain builds.
module tb_cfg_chain_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, word_valid;
  logic [31:0] word_in;
  logic        word_ready, cfg_data, cfg_shift, cfg_rst, busy, done;
  logic [15:0] csum;

  logic        start_s, valid_s;
  logic [31:0] word_s;
  logic        rdy1, dat1, sh1, rst1, busy1, done1;
  logic        rdy2, dat2, sh2, rst2, busy2, done2;
  logic [15:0] csum1, csum2;

  cfg_chain_loader u0 (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .cfg_data(cfg_data), .cfg_shift(cfg_shift), .cfg_rst(cfg_rst),
    .busy(busy), .done(done), .csum(csum));

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(32)) u1 (
    .clk(clk), .reset(reset), .start(start_s), .word_in(word_s), .word_valid(valid_s),
    .word_ready(rdy1), .cfg_data(dat1), .cfg_shift(sh1), .cfg_rst(rst1),
    .busy(busy1), .done(done1), .csum(csum1));

  cfg_chain_loader #(.WORD_W(32), .CHAIN_LEN(1)) u2 (
    .clk(clk), .reset(reset), .start(start_s), .word_in(word_s), .word_valid(valid_s),
    .word_ready(rdy2), .cfg_data(dat2), .cfg_shift(sh2), .cfg_rst(rst2),
    .busy(busy2), .done(done2), .csum(csum2));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [3:0][31:0] w;
    logic [7:0]       gap;
    logic             noise;
    logic [99:0]      exp_stream;
    logic [8:0]       exp_done;
    logic [15:0]      exp_csum;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                              input logic [31:0] d, input int gap, input bit noise,
                              input logic [99:0] s, input int dc, input logic [15:0] cs);
    vec_t v;
    v.w          = {d, c, b, a};
    v.gap        = 8'(gap);
    v.noise      = noise;
    v.exp_stream = s;
    v.exp_done   = 9'(dc);
    v.exp_csum   = cs;
    return v;
  endfunction

  // results of the most recent load on u0
  int          nsh, nrst, ndone, done_cyc, nacc, gapleft;
  logic [99:0] cap;
  bit          side_ok, gap_ok;
  logic        busy_after;

  task automatic run_load(input vec_t v, input bit abort40);
    int widx = 0;
    int cyc = 0;
    bit fin = 0;
    nsh = 0; nrst = 0; ndone = 0; done_cyc = -1; cap = '0;
    side_ok = 1; gap_ok = 1; gapleft = int'(v.gap);
    @(negedge clk);
    reset = 0; start = 1; word_valid = 0;
    while (!fin && cyc < 400) begin
      @(negedge clk);
      cyc++;
      start = v.noise && cyc >= 20 && cyc <= 80 && (cyc % 3 == 0);
      if (cfg_shift) begin
        if (nsh < 100) cap[nsh] = cfg_data;
        nsh++;
      end
      if (!cfg_shift && cfg_data) side_ok = 0;
      if (cfg_shift && word_ready) side_ok = 0;
      if (!busy) side_ok = 0;
`ifndef CFG_LOADER_CSUM_EN
      if (csum !== 16'd0) side_ok = 0;
`endif
      if (cfg_rst) nrst++;
      if (done) begin ndone++; done_cyc = cyc; fin = 1; end
      if (abort40 && nsh == 40) begin
        reset = 1;
        fin = 1;
      end
      word_valid = 0;
      word_in = 32'hDEAD_BEEF;
      if (!fin && word_ready && widx < 4) begin
        if (widx == 1 && gapleft > 0) begin
          gapleft--;
          if (cfg_shift || cfg_rst || done || !busy) gap_ok = 0;
        end else begin
          word_valid = 1;
          word_in = v.w[widx];
          widx++;
        end
      end
    end
    start = 0;
    word_valid = 0;
    nacc = widx;
    if (!abort40) begin
      @(negedge clk);
      busy_after = busy;
      if (done || cfg_shift) side_ok = 0;
    end
  endtask

  int          s_sh1, s_sh2, s_acc1, s_acc2, s_dn1, s_dn2, s_rst1;
  logic [31:0] s_cap1;
  logic        s_cap2;

  task automatic run_small(input logic [31:0] w);
    s_sh1 = 0; s_sh2 = 0; s_acc1 = 0; s_acc2 = 0; s_dn1 = 0; s_dn2 = 0; s_rst1 = 0;
    s_cap1 = '0; s_cap2 = 1'bx;
    @(negedge clk);
    start_s = 1; valid_s = 1; word_s = w;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      start_s = 0;
      if (sh1) begin
        if (s_sh1 < 32) s_cap1[s_sh1] = dat1;
        s_sh1++;
      end
      if (sh2) begin s_cap2 = dat2; s_sh2++; end
      if (rdy1 && valid_s) s_acc1++;
      if (rdy2 && valid_s) s_acc2++;
      if (done1) s_dn1++;
      if (done2) s_dn2++;
      if (rst1) s_rst1++;
    end
    valid_s = 0;
  endtask

  vec_t vecs[4];

  initial begin
    vecs[0] = mk(32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000F, 0, 0,
                 100'hF_FFFF_FFFF_8000_0000_0000_0001, 106, 16'h800E);
    vecs[1] = mk(32'h0000_0001, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_000F, 10, 0,
                 100'hF_FFFF_FFFF_8000_0000_0000_0001, 116, 16'h800E);
    vecs[2] = mk(32'hA5A5_A5A5, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFF3, 0, 1,
                 100'h3_0000_0000_1234_5678_A5A5_A5A5, 106, 16'hB3E8);
    vecs[3] = mk(32'h0001_0002, 32'hFFFF_0001, 32'h0000_0000, 32'h0000_0000, 0, 0,
                 100'h0_0000_0000_FFFF_0001_0001_0002, 106, 16'h0003);

    reset = 1; start = 0; word_valid = 0; word_in = '0;
    start_s = 0; valid_s = 0; word_s = '0;
    repeat (3) @(negedge clk);
    chk("rst_word_ready", word_ready, 0);
    chk("rst_cfg_data",   cfg_data,   0);
    chk("rst_cfg_shift",  cfg_shift,  0);
    chk("rst_cfg_rst",    cfg_rst,    0);
    chk("rst_busy",       busy,       0);
    chk("rst_done",       done,       0);
    chk("rst_csum",       csum,       0);

    for (int i = 0; i < 4; i++) begin
      run_load(vecs[i], 0);
      chk($sformatf("v%0d_stream", i),   cap,        vecs[i].exp_stream);
      chk($sformatf("v%0d_shifts", i),   nsh,        100);
      chk($sformatf("v%0d_cfg_rst", i),  nrst,       1);
      chk($sformatf("v%0d_done_cnt", i), ndone,      1);
      chk($sformatf("v%0d_done_cyc", i), done_cyc,   vecs[i].exp_done);
      chk($sformatf("v%0d_accepts", i),  nacc,       4);
      chk($sformatf("v%0d_idle_busy", i), busy_after, 0);
      chk($sformatf("v%0d_side", i),     side_ok,    1);
      chk($sformatf("v%0d_gap", i),      gap_ok && gapleft == 0, 1);
`ifdef CFG_LOADER_CSUM_EN
      chk($sformatf("v%0d_csum", i),     csum,       vecs[i].exp_csum);
`else
      chk($sformatf("v%0d_csum", i),     csum,       16'd0);
`endif
      repeat (2) @(negedge clk);
    end

    // abort after 40 bits, then confirm the loader stays idle with no done pulse
    run_load(vecs[0], 1);
    chk("abort_bits", cap[39:0], vecs[0].exp_stream[39:0]);
    @(negedge clk);
    chk("abort_busy",  busy,      0);
    chk("abort_shift", cfg_shift, 0);
    begin
      int late = 0;
      reset = 0;
      for (int c = 0; c < 15; c++) begin
        @(negedge clk);
        if (done || cfg_shift || busy) late++;
      end
      chk("abort_quiet", late, 0);
    end
    reset = 1;
    @(negedge clk);
    run_load(vecs[2], 0);
    chk("post_abort_stream", cap,      vecs[2].exp_stream);
    chk("post_abort_shifts", nsh,      100);
    chk("post_abort_done",   ndone,    1);
    chk("post_abort_cyc",    done_cyc, 106);
    chk("post_abort_rst",    nrst,     1);

    run_small(32'h8000_0001);
    chk("c32_stream",  s_cap1, 32'h8000_0001);
    chk("c32_shifts",  s_sh1,  32);
    chk("c32_accepts", s_acc1, 1);
    chk("c32_done",    s_dn1,  1);
    chk("c32_cfg_rst", s_rst1, 1);
    chk("c1_bit",      s_cap2, 1'b1);
    chk("c1_shifts",   s_sh2,  1);
    chk("c1_accepts",  s_acc2, 1);
    chk("c1_done",     s_dn2,  1);
    run_small(32'h7FFF_FFFE);
    chk("c32_stream_b", s_cap1, 32'h7FFF_FFFE);
    chk("c1_bit_b",     s_cap2, 1'b0);
    chk("c1_shifts_b",  s_sh2,  1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
